// File: rtl/big_alu.sv
// 32-bit execute-stage ALU: combinational logic/arith/shift results, plus a
// sequential 32-iteration shift-add unsigned multiplier feeding HI/LO (33-edge latency, no backpressure).
module big_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  signal,
    output logic [31:0] result,
    input  logic        reset,
    input  logic        clk
);

    localparam logic [5:0] OP_SLL   = 6'd0;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_LO    = 6'd60;
    localparam logic [5:0] OP_HI    = 6'd61;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] prod_q,  prod_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        is_mult;
    logic [32:0] add_sum;
    logic [63:0] step_prod;

    assign is_mult = (signal == OP_MULTU);

    always_comb begin
        result = 32'd0;
        case (signal)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_HI:   result = hi_q;
            OP_LO:   result = lo_q;
            default: result = 32'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        // Carry out of the upper-half add is shifted back in as the new MSB.
        add_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
        step_prod = {add_sum, prod_q[31:1]};
        case (state_q)
            IDLE: begin
                if (is_mult) begin
                    mcand_d = a;
                    prod_d  = {32'd0, b};
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!is_mult) begin
                    state_d = IDLE;
                end else begin
                    prod_d = step_prod;
                    cnt_d  = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        hi_d    = step_prod[63:32];
                        lo_d    = step_prod[31:0];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!is_mult) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= 32'd0;
            prod_q  <= 64'd0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_big_alu.sv
// Self-checking bench for big_alu: directed and random ALU ops against an
// arithmetic reference, plus multiply, abort and mid-multiply reset scenarios.
module tb_big_alu;

    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  signal;
    logic [31:0] result;
    logic        reset;
    logic        clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    big_alu dut (
        .a      (a),
        .b      (b),
        .signal (signal),
        .result (result),
        .reset  (reset),
        .clk    (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] hi,
                                            input logic [31:0] lo);
        longint sx, sy;
        int unsigned sh;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = y % 32;
        case (op)
            6'd36:   return x & y;
            6'd37:   return x | y;
            6'd32:   return 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
            6'd34:   return 32'((longint'(x) + 64'h1_0000_0000 - longint'(y)) % 64'h1_0000_0000);
            6'd42:   return (sx < sy) ? 32'd1 : 32'd0;
            6'd0:    return 32'((longint'(x) * (longint'(1) << sh)) % 64'h1_0000_0000);
            6'd2:    return 32'(longint'(x) / (longint'(1) << sh));
            6'd61:   return hi;
            6'd60:   return lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        signal = op;
        a = x;
        b = y;
        #1;
    endtask

    task automatic read_hilo(input string tag);
        apply(6'd61, $urandom, $urandom);
        chk({tag, "_hi"}, result, m_hi);
        apply(6'd60, $urandom, $urandom);
        chk({tag, "_lo"}, result, m_lo);
    endtask

    // Holds MULTU for `hold` rising edges; operands are scrambled after the load edge.
    task automatic do_mult(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input int hold);
        longint unsigned p;
        apply(6'd25, x, y);
        chk({tag, "_busy0"}, result, 32'd0);
        @(posedge clk);
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        #1;
        chk({tag, "_busy1"}, result, 32'd0);
        repeat (hold - 1) @(posedge clk);
        p = longint'(x) * longint'(y);
        if (hold >= 33) begin
            m_hi = p[63:32];
            m_lo = p[31:0];
        end
        read_hilo(tag);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] x, y;

        a = 32'd0;
        b = 32'd0;
        signal = 6'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        read_hilo("reset");
        @(negedge clk);
        reset = 1'b0;

        apply(6'd32, 32'd7, 32'd5);                chk("add", result, 32'd12);
        apply(6'd32, 32'hFFFF_FFFF, 32'd1);        chk("add_wrap", result, 32'd0);
        apply(6'd34, 32'd5, 32'd7);                chk("sub", result, 32'hFFFF_FFFE);
        apply(6'd36, 32'h0000_F0F0, 32'h0000_FF00); chk("and", result, 32'h0000_F000);
        apply(6'd37, 32'h0000_F0F0, 32'h0000_0F0F); chk("or", result, 32'h0000_FFFF);
        apply(6'd42, 32'hFFFF_FFFF, 32'd1);        chk("slt_neg", result, 32'd1);
        apply(6'd42, 32'd3, 32'd3);                chk("slt_eq", result, 32'd0);
        apply(6'd42, 32'd5, 32'hFFFF_FFFE);        chk("slt_pos", result, 32'd0);
        apply(6'd0, 32'd1, 32'd31);                chk("sll31", result, 32'h8000_0000);
        apply(6'd2, 32'h8000_0000, 32'd31);        chk("srl31", result, 32'd1);
        apply(6'd2, 32'h0000_00FF, 32'd36);        chk("srl_mask", result, 32'h0000_000F);
        apply(6'd63, 32'h1234_5678, 32'h1);        chk("undef", result, 32'd0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: op = 6'd36;  1: op = 6'd37;  2: op = 6'd32;  3: op = 6'd34;
                4: op = 6'd42;  5: op = 6'd0;   6: op = 6'd2;   7: op = 6'd61;
                8: op = 6'd60;  default: op = 6'($urandom);
            endcase
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            apply(op, x, y);
            chk($sformatf("rand%0d_op%0d", i, op), result, ref_alu(op, x, y, m_hi, m_lo));
        end

        do_mult("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_mult("mul_spec", 32'd123456, 32'd654321, 33);
        do_mult("mul_hold", 32'hDEAD_BEEF, 32'h0000_0003, 45);
        for (int i = 0; i < 4; i++) begin
            do_mult($sformatf("mul_rand%0d", i), $urandom, $urandom, 33);
        end
        do_mult("mul_abort", 32'h1111_1111, 32'h2222_2222, 10);

        // Mid-multiply reset: HI/LO must clear and a fresh multiply must still work.
        apply(6'd25, 32'hABCD_1234, 32'h5678_9ABC);
        repeat (12) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        signal = 6'd61;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        read_hilo("mid_reset");
        do_mult("mul_3x4", 32'd3, 32'd4, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
